// File: rtl/piso_serializer.sv
// piso_serializer: sends a WIDTH-bit word on Sout one bit per clock after a Load/Ready accept, then pulses Done
module piso_serializer #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Din,
  input  logic             Load,
  output logic             Ready,
  output logic             Busy,
  output logic             Sout,
  output logic             Done
);
  localparam int cw = $clog2(WIDTH);
  localparam logic [cw-1:0] last_bit = cw'(WIDTH - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [WIDTH-1:0] sreg;
  logic [cw-1:0] cnt;
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      Ready <= 1'b1;
      Busy  <= 1'b0;
      Sout  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (state == IDLE) begin
        if (Load && Ready) begin
          // first bit leaves immediately, so the register keeps only the rest
          state <= SHIFT;
          Sout  <= MSB_FIRST ? Din[WIDTH-1] : Din[0];
          sreg  <= MSB_FIRST ? Din << 1 : Din >> 1;
          cnt   <= '0;
          Busy  <= 1'b1;
          Ready <= 1'b0;
        end
      end else if (cnt == last_bit) begin
        state <= IDLE;
        Sout  <= 1'b0;
        Busy  <= 1'b0;
        Ready <= 1'b1;
        Done  <= 1'b1;
      end else begin
        Sout <= MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
        sreg <= MSB_FIRST ? sreg << 1 : sreg >> 1;
        cnt  <= cnt + cw'(1);
      end
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: bit-queue reference model for both bit orders plus directed frames with literal expectations
module tb_piso_serializer;
  logic Clock = 1'b0;
  logic Reset;
  logic [7:0] Din;
  logic Load;
  logic ready1, busy1, sout1, done1;
  logic ready0, busy0, sout0, done0;
  int passed = 0;
  int total = 0;
  bit chk_on = 0;
  bit q1[$];
  bit q0[$];
  bit e_done;
  always #5 Clock = ~Clock;
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) d1 (
    .Clock(Clock), .Reset(Reset), .Din(Din), .Load(Load),
    .Ready(ready1), .Busy(busy1), .Sout(sout1), .Done(done1)
  );
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) d0 (
    .Clock(Clock), .Reset(Reset), .Din(Din), .Load(Load),
    .Ready(ready0), .Busy(busy0), .Sout(sout0), .Done(done0)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask
  // Model: the queue holds the bits still to appear on Sout, front = bit on the wire now
  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      q1.delete();
      q0.delete();
      e_done = 0;
    end else begin
      e_done = (q1.size() == 1);
      if (q1.size() > 0) begin
        void'(q1.pop_front());
        void'(q0.pop_front());
      end else if (Load === 1'b1) begin
        for (int i = 0; i < 8; i++) begin
          q1.push_back(Din[7-i]);
          q0.push_back(Din[i]);
        end
      end
    end
  end
  always @(negedge Clock) begin
    if (chk_on) begin
      check("sout_msb", sout1, q1.size() > 0 ? q1[0] : 1'b0);
      check("busy_msb", busy1, q1.size() > 0);
      check("ready_msb", ready1, q1.size() == 0);
      check("done_msb", done1, e_done);
      check("sout_lsb", sout0, q0.size() > 0 ? q0[0] : 1'b0);
      check("busy_lsb", busy0, q0.size() > 0);
      check("ready_lsb", ready0, q0.size() == 0);
      check("done_lsb", done0, e_done);
    end
  end
  // Called just after the accept edge; returns the 8 bits in wire order and Done in cycle 9
  task automatic capture(output logic [7:0] c1, output logic [7:0] c0, output logic d9);
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      c1 = {c1[6:0], sout1};
      c0 = {c0[6:0], sout0};
    end
    @(negedge Clock);
    d9 = done1 & done0;
  endtask
  task automatic idle_reset_check(input string name);
    check({name, "_ready"}, {ready1, ready0}, 2'b11);
    check({name, "_busy"}, {busy1, busy0}, 2'b00);
    check({name, "_sout"}, {sout1, sout0}, 2'b00);
    check({name, "_done"}, {done1, done0}, 2'b00);
  endtask
  initial begin
    logic [7:0] c1, c0;
    logic d9;
    int n, dones;
    bit prev_busy;
    Reset = 1'b0;
    Load = 1'b0;
    Din = 8'h00;
    #1 Reset = 1'b1;
    #1 idle_reset_check("reset_async");
    repeat (2) @(posedge Clock);
    #2 Reset = 1'b0;
    chk_on = 1;
    @(posedge Clock); #2;
    Din = 8'hC4; Load = 1'b1;
    @(posedge Clock); #2;
    Load = 1'b0;
    capture(c1, c0, d9);
    check("c4_msb_bits", c1, 8'b1100_0100);
    check("c4_lsb_bits", c0, 8'b0010_0011);
    check("c4_done9", d9, 1'b1);
    @(negedge Clock);
    check("c4_done10", done1, 1'b0);
    @(posedge Clock); #2;
    Din = 8'hC4; Load = 1'b1;
    @(posedge Clock); #2;
    Load = 1'b0;
    fork
      capture(c1, c0, d9);
      begin
        repeat (2) @(posedge Clock);
        #2 Din = 8'hFF; Load = 1'b1;
      end
    join
    check("busy_ignore_msb", c1, 8'b1100_0100);
    check("busy_ignore_lsb", c0, 8'b0010_0011);
    check("busy_ignore_done", d9, 1'b1);
    @(posedge Clock); #2;
    Load = 1'b0;
    repeat (10) @(posedge Clock); #2;
    Din = 8'hAA; Load = 1'b1;
    @(posedge Clock); #2;
    Din = 8'h55;
    n = 0; dones = 0; prev_busy = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge Clock);
      n++;
      if (done1) dones++;
      if (n > 1 && busy1 && !prev_busy) break;
      prev_busy = busy1;
    end
    check("b2b_period", n, 10);
    check("b2b_dones", dones, 1);
    Load = 1'b0;
    repeat (12) @(posedge Clock); #2;
    Din = 8'hC4; Load = 1'b1;
    @(posedge Clock); #2;
    Load = 1'b0;
    repeat (3) @(posedge Clock);
    #2 Reset = 1'b1;
    #1 idle_reset_check("reset_midframe");
    repeat (2) @(posedge Clock);
    #2 Reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clock);
      check("no_done_after_abort", done1 | done0, 1'b0);
    end
    @(posedge Clock); #2;
    Din = 8'h0F; Load = 1'b1;
    @(posedge Clock); #2;
    Load = 1'b0;
    capture(c1, c0, d9);
    check("0f_msb_bits", c1, 8'b0000_1111);
    check("0f_lsb_bits", c0, 8'b1111_0000);
    check("0f_done9", d9, 1'b1);
    repeat (3) @(negedge Clock);
    chk_on = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
